// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter for SLL, SRL and SRA, with valid/ready handshakes and a global stall.
// Each stage resolves one shamt bit. Define PIPELINED_SHIFTER_ROTATE_EN to make mode 2'b11 a rotate-left.
module pipelined_shifter #(
  parameter int N = 32,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] i_data,
  input  logic [S-1:0] i_shamt,
  input  logic [1:0]   i_mode,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] o_data,
  output logic         o_zero
);

  logic [N-1:0] stg_data  [S];
  logic [S-1:0] stg_shamt [S];
  logic [1:0]   stg_mode  [S];
  logic         stg_sign  [S];
  logic         stg_valid [S];
  logic         adv;

  // One advance signal stalls every stage together, so bubbles keep their position.
  assign adv     = !stg_valid[S-1] || o_ready;
  assign i_ready = adv;
  assign o_valid = stg_valid[S-1];
  assign o_data  = stg_data[S-1];
  assign o_zero  = (stg_data[S-1] == '0);

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int AMT = 1 << k;

    logic [N-1:0] src_data;
    logic [N-1:0] shifted;
    logic [S-1:0] src_shamt;
    logic [1:0]   src_mode;
    logic         src_sign;
    logic         src_valid;
    logic         src_bit;

    if (k == 0) begin : g_first
      assign src_data  = i_data;
      assign src_shamt = i_shamt;
      assign src_mode  = i_mode;
      assign src_sign  = i_data[N-1];
      assign src_valid = i_valid;
    end else begin : g_next
      assign src_data  = stg_data[k-1];
      assign src_shamt = stg_shamt[k-1];
      assign src_mode  = stg_mode[k-1];
      assign src_sign  = stg_sign[k-1];
      assign src_valid = stg_valid[k-1];
    end

    assign src_bit = src_shamt[k];

    always_comb begin
      shifted = src_data;
      if (src_bit) begin
        case (src_mode)
          2'b00:   shifted = {src_data[N-1-AMT:0], {AMT{1'b0}}};
          2'b01:   shifted = {{AMT{1'b0}}, src_data[N-1:AMT]};
          2'b10:   shifted = {{AMT{src_sign}}, src_data[N-1:AMT]};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
          2'b11:   shifted = {src_data[N-1-AMT:0], src_data[N-1:N-AMT]};
`endif
          default: shifted = src_data;
        endcase
      end
    end

    // The sign travels with the operation so SRA fills from the operand's original MSB.
    always_ff @(posedge clk) begin
      if (rst) begin
        stg_valid[k] <= 1'b0;
        stg_data[k]  <= '0;
        stg_shamt[k] <= '0;
        stg_mode[k]  <= '0;
        stg_sign[k]  <= 1'b0;
      end else if (adv) begin
        stg_valid[k] <= src_valid;
        stg_data[k]  <= shifted;
        stg_shamt[k] <= src_shamt;
        stg_mode[k]  <= src_mode;
        stg_sign[k]  <= src_sign;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed testbench for pipelined_shifter (N=32, five stages).
// Expected values are hand-computed; mode 2'b11 expectations follow PIPELINED_SHIFTER_ROTATE_EN.
module tb_pipelined_shifter;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;
  logic [4:0]  i_shamt;
  logic [1:0]  i_mode;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_zero;

  int total = 0;
  int bad   = 0;
  int lat;
  int rx;
  int nxt;
  int stall_cycles;
  logic        stalled;
  logic [31:0] held;
  logic [31:0] rol_expected;

  logic [31:0] st_in  [8] = '{32'h0000_00FF, 32'hFF00_0000, 32'h8000_0000, 32'h1234_5678,
                              32'h1234_5678, 32'hF000_0000, 32'h4000_0000, 32'h0000_0003};
  logic [4:0]  st_sh  [8] = '{5'd4, 5'd8, 5'd1, 5'd16, 5'd4, 5'd28, 5'd30, 5'd30};
  logic [1:0]  st_md  [8] = '{SLL, SRL, SRA, SLL, SRL, SRA, SRA, SLL};
  logic [31:0] st_exp [8] = '{32'h0000_0FF0, 32'h00FF_0000, 32'hC000_0000, 32'h5678_0000,
                              32'h0123_4567, 32'hFFFF_FFFF, 32'h0000_0001, 32'hC000_0000};

  pipelined_shifter #(.N(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_shamt (i_shamt),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_zero  (o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not terminate");
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] sh,
                               input logic [1:0] md);
    i_valid = v;
    i_data  = d;
    i_shamt = sh;
    i_mode  = md;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one op for a single cycle, then waits a bounded time for its result.
  task automatic runOp(input string tag, input logic [31:0] d, input logic [4:0] sh,
                       input logic [1:0] md, input logic [31:0] expected);
    applyStimulus(1'b1, d, sh, md);
    checkOutput({tag, " i_ready"}, 32'(i_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'd5);
    checkOutput({tag, " data"}, o_data, expected);
    checkOutput({tag, " zero"}, 32'(o_zero), 32'(expected == 32'h0));
  endtask

  initial begin
    rst     = 1'b1;
    o_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset o_valid", 32'(o_valid), 32'd0);
    checkOutput("reset o_data", o_data, 32'h0);
    checkOutput("reset o_zero", 32'(o_zero), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset i_ready", 32'(i_ready), 32'd1);
    checkOutput("post-reset o_valid", 32'(o_valid), 32'd0);

    runOp("sll 1<<31", 32'h0000_0001, 5'd31, SLL, 32'h8000_0000);
    runOp("sll ones<<31", 32'hFFFF_FFFF, 5'd31, SLL, 32'h8000_0000);
    runOp("srl 1>>1", 32'h0000_0001, 5'd1, SRL, 32'h0000_0000);
    runOp("sra neg>>31", 32'h8000_0000, 5'd31, SRA, 32'hFFFF_FFFF);
    runOp("sra pos>>4", 32'h7000_0000, 5'd4, SRA, 32'h0700_0000);
    runOp("srl >>8", 32'hF000_000F, 5'd8, SRL, 32'h00F0_0000);
    runOp("sll sh0", 32'hDEAD_BEEF, 5'd0, SLL, 32'hDEAD_BEEF);
    runOp("srl sh0", 32'hDEAD_BEEF, 5'd0, SRL, 32'hDEAD_BEEF);
    runOp("sra sh0", 32'hDEAD_BEEF, 5'd0, SRA, 32'hDEAD_BEEF);
    runOp("mode3 sh0", 32'hDEAD_BEEF, 5'd0, ROL, 32'hDEAD_BEEF);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    rol_expected = 32'h0000_0003;
`else
    rol_expected = 32'h8000_0001;
`endif
    runOp("mode3 sh1", 32'h8000_0001, 5'd1, ROL, rol_expected);

    // SRL then SRA on consecutive cycles must come out on consecutive cycles.
    @(negedge clk);
    applyStimulus(1'b1, 32'h8000_0000, 5'd4, SRL);
    @(negedge clk);
    applyStimulus(1'b1, 32'h8000_0000, 5'd4, SRA);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    lat = 2;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b first latency", 32'(lat), 32'd5);
    checkOutput("b2b srl data", o_data, 32'h0800_0000);
    @(negedge clk);
    checkOutput("b2b second valid", 32'(o_valid), 32'd1);
    checkOutput("b2b sra data", o_data, 32'hF800_0000);
    @(negedge clk);
    @(negedge clk);

    // Eight ops streamed with o_ready low in cycles 6-9.
    rx = 0;
    nxt = 0;
    stalled = 1'b0;
    stall_cycles = 0;
    held = 32'h0;
    for (int c = 1; c <= 60 && rx < 8; c++) begin
      o_ready = !(c >= 6 && c <= 9);
      if (nxt < 8) applyStimulus(1'b1, st_in[nxt], st_sh[nxt], st_md[nxt]);
      else         applyStimulus(1'b0, 32'h0, 5'd0, SLL);
      #1;
      if (o_valid && !o_ready) begin
        stall_cycles++;
        checkOutput($sformatf("stall i_ready c%0d", c), 32'(i_ready), 32'd0);
        if (stalled) checkOutput($sformatf("stall hold c%0d", c), o_data, held);
        else         held = o_data;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (o_valid && o_ready && rx < 8) begin
        checkOutput($sformatf("stream result %0d", rx), o_data, st_exp[rx]);
        rx++;
      end
      if (i_valid && i_ready) nxt++;
      @(negedge clk);
    end
    o_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    checkOutput("stream count", 32'(rx), 32'd8);
    checkOutput("stream stall cycles", 32'(stall_cycles), 32'd4);
    checkOutput("stream no duplicate", 32'(o_valid), 32'd0);
    @(negedge clk);

    // Three ops in flight are flushed by a one-cycle reset.
    applyStimulus(1'b1, 32'h1111_1111, 5'd1, SLL);
    @(negedge clk);
    applyStimulus(1'b1, 32'h2222_2222, 5'd2, SRL);
    @(negedge clk);
    applyStimulus(1'b1, 32'h3333_3333, 5'd3, SRA);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("flush o_valid", 32'(o_valid), 32'd0);
    checkOutput("flush i_ready", 32'(i_ready), 32'd1);
    checkOutput("flush o_data", o_data, 32'h0);
    runOp("after flush", 32'h0000_00F0, 5'd4, SLL, 32'h0000_0F00);
    @(negedge clk);
    checkOutput("after flush drain", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, fully pipelined barrel shifter. Supports logical left, logical right and arithmetic right shift, with an optional rotate-left mode.
- Generalises the single-cycle 32-bit left shifter to any power-of-two width N, with one shamt bit resolved per stage.
- Valid/ready handshakes on input and output. Throughput is one operation per cycle with full backpressure.
- Sits between the ALU operand muxes and the writeback register in the multi-cycle core.

Parameters:
- N, 32, data width in bits; must be a power of two, N >= 2.
- S, $clog2(N) (derived localparam, not overridable), number of pipeline stages and width of shamt.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  input operation present
- i_ready  output  1  block can accept an operation this cycle
- i_data  input  N  operand to shift
- i_shamt  input  S  shift amount, 0..N-1
- i_mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROL (see Optional Feature)
- o_valid  output  1  result present
- o_ready  input  1  downstream accepts result
- o_data  output  N  shifted result
- o_zero  output  1  o_data == 0, valid when o_valid

Behaviour:
- Reset: on rising clk with rst=1, all stage valid bits clear.
  - o_valid=0, o_data=0, o_zero=1.
  - i_ready=1 in the first cycle after reset deasserts.
  - Stage data registers are cleared to 0.
- Pipeline: S registered stages.
  - Stage k (k=0..S-1) shifts by 2^k when captured shamt bit k=1, otherwise passes through.
  - Each stage carries data, remaining shamt, mode and a valid bit.
- Advance condition: adv = !o_valid || o_ready. Every stage loads from its predecessor when adv=1 and holds when adv=0 (global stall).
- i_ready = adv, combinational from o_valid and o_ready. An input transfer occurs when i_valid && i_ready.
- Latency: a result is on o_data/o_valid exactly S cycles after acceptance, with no stalls in between. Each stall cycle adds one cycle.
- Throughput: back-to-back inputs produce back-to-back outputs in the same order. Pipeline bubbles are preserved, not compressed.
- Output transfer occurs when o_valid && o_ready. While o_valid=1 && o_ready=0, o_data, o_zero and o_valid hold stable.
- Shift rules:
  - SLL fills vacated LSBs with 0.
  - SRL fills vacated MSBs with 0.
  - SRA fills vacated MSBs with i_data[N-1], the sign captured at input.
- shamt=0: output equals input for every mode.
- shamt=N-1, SLL: out = {in[0], (N-1) zeros}.
- shamt=N-1, SRA of a negative operand: out = all ones.
- Width: shamt is S bits, so no amount >= N is representable and no saturation logic is required.
- Reset mid-operation: rst dominates adv. All in-flight operations are discarded, no partial result is emitted, and i_ready=1 on the next cycle.
- Simultaneous input acceptance and output transfer in the same cycle is legal and is the steady-state case.

Optional Feature:
- Macro: PIPELINED_SHIFTER_ROTATE_EN
- Defined: i_mode=11 performs rotate-left. Bits shifted out of the MSB re-enter at the LSB, per stage.
- Not defined: i_mode=11 passes data through unchanged, ignoring shamt, with the same latency and handshake. No rotate logic is synthesised.

Test Plan:
- N=32, SLL, in=0x0000_0001, shamt=31, o_ready=1 -> o_data=0x8000_0000, o_valid rises 5 cycles after acceptance, o_zero=0.
- SRL and SRA back-to-back on consecutive cycles, in=0x8000_0000, shamt=4 -> 0x0800_0000 then 0xF800_0000 on consecutive cycles. Also shamt=0, in=0xDEAD_BEEF -> 0xDEAD_BEEF for all modes.
- Stall test: stream 8 ops with o_ready low for cycles 6-9.
  - i_ready must be 0 while o_valid=1 and o_ready=0.
  - o_data must hold stable through the stall.
  - All 8 results must emerge in order, none dropped or duplicated.
- SLL in=0xFFFF_FFFF, shamt=31, then SRL in=0x0000_0001, shamt=1 -> 0x8000_0000 then 0x0000_0000 with o_zero=1.
- Reset mid-stream: assert rst for 1 cycle with 3 ops in flight.
  - The next cycle must show o_valid=0, i_ready=1.
  - None of the 3 flushed results appear.
  - The next accepted op returns correctly after 5 cycles.
- With PIPELINED_SHIFTER_ROTATE_EN: mode=11, in=0x8000_0001, shamt=1 -> 0x0000_0003.
- Without PIPELINED_SHIFTER_ROTATE_EN: mode=11, in=0x8000_0001, shamt=1 -> 0x8000_0001.
